dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter and sequencer for the single-port data memory in the 5-stage pipeline. It shares the memory between the pipeline MEM stage (core port) and a DMA/loader port (req/ack handshake), which is used for test-bench preload and debug readback. The core has priority. A starvation counter forces a one-cycle DMA slot so the DMA port is never locked out. It sits between the EX/MEM pipeline register and the data memory, and drives the MEM-stage stall.

## Interface
- DEPTH, 64: memory words; the index is the low $clog2(DEPTH) bits of the address
- STARVE_LIMIT, 4: cycles a pending DMA request may be blocked before the core is stalled
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- core_mem_read  in  1  MEM-stage load
- core_mem_write  in  1  MEM-stage store
- core_addr  in  32  word address
- core_wdata  in  32  store data
- core_rdata  out  32  load data (combinational)
- core_stall  out  1  freeze the MEM stage and earlier stages this cycle
- dma_req  in  1  DMA request, held until dma_ack
- dma_we  in  1  1 = write, 0 = read; stable while dma_req is high
- dma_addr  in  32  word address; stable while dma_req is high
- dma_wdata  in  32  write data; stable while dma_req is high
- dma_ack  out  1  single-cycle completion pulse
- dma_rdata  out  32  read data, valid while dma_ack is high
- mem_read, mem_write  out  1 each  data memory strobes
- mem_addr, mem_wdata  out  32 each  data memory address and write data
- mem_rdata  in  32  data memory read data
- addr_err  out  1  out-of-range access (only with the macro defined)

## Operation
- core_active = core_mem_read | core_mem_write.
- FSM states: IDLE, GRANT, ACK. Reset state is IDLE.
- IDLE:
  - The core owns the memory port.
  - If dma_req and (!core_active or starve_cnt == STARVE_LIMIT), go to GRANT.
  - Otherwise, if dma_req and core_active, starve_cnt increments and saturates at STARVE_LIMIT.
- GRANT:
  - The memory port is driven from the DMA inputs.
  - core_stall = core_active.
  - dma_rdata <= mem_rdata on the clock edge when !dma_we.
  - starve_cnt clears to 0. Next state is ACK.
- ACK:
  - dma_ack = 1 and the core owns the port again.
  - The DMA master drops dma_req in this cycle. A dma_req still high in the following IDLE cycle is a new request.
  - Next state is IDLE.
- While the core owns the port, mem_* and core_rdata are pure pass-through; core_stall = 0.
- While the core does not own the port, core_rdata = 0.
- A core access that is stalled in GRANT is replayed unchanged in the next cycle; the arbiter holds no copy of it.
- Reset values: state IDLE, starve_cnt 0, dma_rdata 0, dma_ack 0, core_stall 0, mem_read 0, mem_write 0, addr_err 0.
- On reset mid-GRANT, the strobes drop asynchronously. A DMA write is committed only if the clock edge that ends GRANT occurred before reset was asserted. No ack is issued for an aborted request.

## Timing
- Core access: 0 extra cycles when DMA is idle; 1 stall cycle per DMA grant that overlaps it.
- DMA with the core idle: req at cycle N, GRANT at N+1, dma_ack at N+2.
- DMA while the core is busy every cycle: dma_ack at N+STARVE_LIMIT+2.
- Back-to-back DMA: at most one request per 3 cycles.
- core_stall, mem_* and core_rdata are combinational from the state and the inputs. dma_ack and dma_rdata are registered.

## Configuration
- DMEM_ARB_BOUNDS_CHECK_EN
- Defined:
  - An access whose address is >= DEPTH suppresses mem_write and mem_read and returns 0 read data.
  - addr_err is high in that cycle. For a DMA access, that is the GRANT cycle.
  - The FSM advances normally, so a DMA request still receives dma_ack.
- Undefined:
  - Addresses pass through unchecked.
  - addr_err is tied to 0.

## Structure
- Package dmem_arb_pkg holds the state enum (IDLE/GRANT/ACK) and the DEPTH_W = $clog2(DEPTH) helper.
- One sub-module is natural: dmem_arb_starve_ctr, the saturating counter with clear and limit-compare output.
- All port muxing stays in the top module.

## Test plan
- Core loads and stores only, addresses 0..63, DMA idle -> core_stall is never 1 and core_rdata matches the memory model with 0 latency.
- DMA write of addr 10 = 0x45 with the core idle -> dma_ack 2 cycles after req. A core load of addr 10 then returns 0x45.
- Core busy every cycle, DMA read of addr 11 pending -> core_stall for exactly 1 cycle, after 4 blocked cycles. dma_ack is high one cycle later with dma_rdata set to the addr-11 value.
- DMA grant overlapping a core store to addr 5 -> the store is held and completes in the ACK cycle. Memory holds the core value and the DMA access is unaffected.
- reset asserted during GRANT of a DMA write -> mem_write drops immediately, no dma_ack, state IDLE, all outputs at their reset values.
- With DMEM_ARB_BOUNDS_CHECK_EN, a core store to addr 64 -> addr_err = 1, mem_write = 0, memory unchanged. Without the macro, addr_err stays 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and helpers for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    // Index width of a memory with the given number of words.
    function automatic int depth_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arb_starve_ctr.sv
// ============================================================================
// Module      : dmem_arb_starve_ctr
// Description : Saturating DMA starvation counter with clear and limit flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam int                 c_CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(LIMIT);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_at_limit) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign o_at_limit = (r_cnt == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Core-priority arbiter for the single-port data memory with a
//               starvation-bounded DMA/loader port. Optional address bounds
//               checking is enabled by defining DMEM_ARB_BOUNDS_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_mem_read,
    input  logic        core_mem_write,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        addr_err
);

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    localparam bit c_BOUNDS_EN = 1'b1;
`else
    localparam bit c_BOUNDS_EN = 1'b0;
`endif

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    logic        r_dma_ack;
    logic [31:0] r_dma_rdata;

    logic w_core_active;
    logic w_core_oob;
    logic w_dma_oob;
    logic w_at_limit;
    logic w_dma_go;
    logic w_starve_inc;
    logic w_starve_clr;

    assign w_core_active = core_mem_read | core_mem_write;
    assign w_core_oob    = c_BOUNDS_EN && (core_addr >= 32'(DEPTH));
    assign w_dma_oob     = c_BOUNDS_EN && (dma_addr  >= 32'(DEPTH));

    // The DMA wins a slot when the core is idle or has starved it long enough.
    assign w_dma_go     = dma_req && (!w_core_active || w_at_limit);
    assign w_starve_inc = (r_state == IDLE) && dma_req && w_core_active && !w_dma_go;
    assign w_starve_clr = (r_state == GRANT);

    dmem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .rst        (reset),
        .i_inc      (w_starve_inc),
        .i_clr      (w_starve_clr),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_dma_ack   <= 1'b0;
            r_dma_rdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_dma_ack <= (r_state == GRANT);
            if ((r_state == GRANT) && !dma_we) begin
                r_dma_rdata <= w_dma_oob ? '0 : mem_rdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_dma_go) w_state_nxt = GRANT;
            GRANT:   w_state_nxt = ACK;
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Port mux: DMA owns the memory only during GRANT; a stalled core access
    // is simply re-presented by the pipeline in the following cycle.
    always_comb begin
        mem_read   = core_mem_read  && !w_core_oob;
        mem_write  = core_mem_write && !w_core_oob;
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        core_rdata = w_core_oob ? '0 : mem_rdata;
        core_stall = 1'b0;
        addr_err   = w_core_oob && w_core_active;
        if (r_state == GRANT) begin
            mem_read   = !dma_we && !w_dma_oob;
            mem_write  = dma_we  && !w_dma_oob;
            mem_addr   = dma_addr;
            mem_wdata  = dma_wdata;
            core_rdata = '0;
            core_stall = w_core_active;
            addr_err   = w_dma_oob;
        end
    end

    assign dma_ack   = r_dma_ack;
    assign dma_rdata = r_dma_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter with a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_mem_read, core_mem_write;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        addr_err;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] core_q[$];
    logic [31:0] dma_q[$];

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[5:0]];

    dmem_arbiter #(
        .DEPTH        (64),
        .STARVE_LIMIT (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .core_mem_read  (core_mem_read),
        .core_mem_write (core_mem_write),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_rdata     (core_rdata),
        .core_stall     (core_stall),
        .dma_req        (dma_req),
        .dma_we         (dma_we),
        .dma_addr       (dma_addr),
        .dma_wdata      (dma_wdata),
        .dma_ack        (dma_ack),
        .dma_rdata      (dma_rdata),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .addr_err       (addr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a result.
    always @(negedge clk) begin
        if (!reset) begin
            if (core_mem_read && !core_stall) begin
                if (core_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL core_load_unexpected: got 0x%08h expected no load", core_rdata);
                end else begin
                    check("core_rdata", core_rdata, core_q.pop_front());
                end
            end
            if (dma_ack) begin
                if (dma_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL dma_ack_unexpected: got ack=1 expected ack=0");
                end else begin
                    check("dma_rdata", dma_rdata, dma_q.pop_front());
                end
            end
        end
    end

    task automatic core_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp, output int stalls);
        stalls = 0;
        if (!we) core_q.push_back(exp);
        core_mem_read  = !we;
        core_mem_write = we;
        core_addr      = addr;
        core_wdata     = wd;
        @(negedge clk);
        while (core_stall && stalls < 8) begin
            stalls++;
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        if (core_stall) begin
            n_checks++;
            n_err++;
            $display("FAIL core_stall_timeout: got stall=1 expected release within 8 cycles");
        end
        @(posedge clk);
        #1;
        core_mem_read  = 1'b0;
        core_mem_write = 1'b0;
    endtask

    task automatic dma_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input int exp_lat, input string name);
        int lat;
        lat = 0;
        dma_q.push_back(exp_rd);
        dma_req   = 1'b1;
        dma_we    = we;
        dma_addr  = addr;
        dma_wdata = wd;
        @(negedge clk);
        while (!dma_ack && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            @(negedge clk);
        end
        dma_req = 1'b0;
        check(name, 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int s;
        int tot;
        int ld_list [8];
        ld_list = '{0, 1, 7, 31, 32, 40, 62, 63};

        reset = 1'b1;
        core_mem_read = 1'b0; core_mem_write = 1'b0; core_addr = '0; core_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dma_ack",    32'(dma_ack),    0);
        check("rst_dma_rdata",  dma_rdata,       0);
        check("rst_core_stall", 32'(core_stall), 0);
        check("rst_mem_read",   32'(mem_read),   0);
        check("rst_mem_write",  32'(mem_write),  0);
        check("rst_addr_err",   32'(addr_err),   0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Core-only traffic: fill memory, read back with zero latency.
        tot = 0;
        for (int i = 0; i < 64; i++) begin
            core_op(1'b1, 32'(i), 32'h1000 + 32'(i), 32'h0, s);
            tot += s;
        end
        for (int i = 0; i < 8; i++) begin
            core_op(1'b0, 32'(ld_list[i]), 32'h0, 32'h1000 + 32'(ld_list[i]), s);
            tot += s;
        end
        check("t1_no_stall", 32'(tot), 0);

        // DMA write with the core idle.
        dma_op(1'b1, 32'd10, 32'h45, 32'h0, 2, "t2_dma_lat");
        core_op(1'b0, 32'd10, 32'h0, 32'h45, s);

        // Core busy every cycle while a DMA read waits out the starvation limit.
        fork
            dma_op(1'b0, 32'd11, 32'h0, 32'h100B, 6, "t3_dma_lat");
            begin
                int st;
                int s3;
                st = 0;
                for (int k = 0; k < 10; k++) begin
                    core_op(1'b0, 32'(20 + k), 32'h0, 32'h1014 + 32'(k), s3);
                    st += s3;
                end
                check("t3_stalls", 32'(st), 1);
            end
        join

        // Core store overlapping a DMA grant is replayed in the ACK cycle.
        fork
            dma_op(1'b0, 32'd12, 32'h0, 32'h100C, 2, "t4_dma_lat");
            begin
                int s4;
                @(posedge clk);
                #1;
                core_op(1'b1, 32'd5, 32'hC5, 32'h0, s4);
                check("t4_store_stalls", 32'(s4), 1);
            end
        join
        core_op(1'b0, 32'd5, 32'h0, 32'hC5, s);

        // Reset asserted in the middle of a DMA write grant.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'd13; dma_wdata = 32'hDEAD;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_grant_mem_write", 32'(mem_write), 1);
        #1;
        reset = 1'b1;
        #1;
        check("t5_rst_mem_write",  32'(mem_write),  0);
        check("t5_rst_mem_read",   32'(mem_read),   0);
        check("t5_rst_dma_ack",    32'(dma_ack),    0);
        check("t5_rst_core_stall", 32'(core_stall), 0);
        check("t5_rst_dma_rdata",  dma_rdata,       0);
        check("t5_rst_addr_err",   32'(addr_err),   0);
        dma_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_no_ack", 32'(dma_ack), 0);
        @(posedge clk);
        #1;
        core_op(1'b0, 32'd13, 32'h0, 32'h100D, s);
        dma_op(1'b0, 32'd13, 32'h0, 32'h100D, 2, "t5_dma_after_rst");

        // Out-of-range store to address 64.
        core_mem_write = 1'b1; core_addr = 32'd64; core_wdata = 32'hBAD;
        @(negedge clk);
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        check("t6_addr_err",  32'(addr_err),  1);
        check("t6_mem_write", 32'(mem_write), 0);
`else
        check("t6_addr_err",  32'(addr_err),  0);
        check("t6_mem_write", 32'(mem_write), 1);
`endif
        @(posedge clk);
        #1;
        core_mem_write = 1'b0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        core_op(1'b0, 32'd64, 32'h0, 32'h0, s);
        core_op(1'b0, 32'd0,  32'h0, 32'h1000, s);
        dma_op(1'b0, 32'd70, 32'h0, 32'h0, 2, "t6_dma_oob_lat");
`else
        core_op(1'b0, 32'd64, 32'h0, 32'hBAD, s);
        core_op(1'b0, 32'd0,  32'h0, 32'hBAD, s);
        dma_op(1'b0, 32'd70, 32'h0, 32'h1006, 2, "t6_dma_wrap_lat");
`endif

        repeat (3) @(posedge clk);
        check("queues_drained", 32'(core_q.size() + dma_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
